// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache backing-store bus: widths, responder
// FSM states and the address decode used by the responder and the checker.
package cache_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StGntWait,
        StResp,
        StCooldown
    } resp_state_e;

    typedef struct packed {
        logic              in_range;
        logic [ADDR_W-1:0] index;
    } addr_dec_t;

    // Word index relative to base; the unsigned subtraction wraps, so the
    // explicit lower-bound test is what rejects addresses below base.
    function automatic addr_dec_t addr_decode(input logic [ADDR_W-1:0] addr,
                                              input logic [ADDR_W-1:0] base,
                                              input logic [ADDR_W-1:0] words);
        addr_dec_t         dec;
        logic [ADDR_W-1:0] offset;
        offset       = addr - base;
        dec.index    = offset >> 2;
        dec.in_range = (addr >= base) && (dec.index < words);
        return dec;
    endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Backing-store bus between the cache (master) and the memory responder (slave).
interface cache_mem_responder_if;
    import cache_bus_pkg::*;

    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_we_i;
    logic              mem_req_i;
    logic [BE_W-1:0]   mem_be_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_gnt_o;
    logic              mem_rvalid_o;
    logic              mem_error_o;

    modport master (
        output mem_addr_i, mem_wdata_i, mem_we_i, mem_req_i, mem_be_i,
        input  mem_rdata_o, mem_gnt_o, mem_rvalid_o, mem_error_o
    );

    modport slave (
        input  mem_addr_i, mem_wdata_i, mem_we_i, mem_req_i, mem_be_i,
        output mem_rdata_o, mem_gnt_o, mem_rvalid_o, mem_error_o
    );

endinterface

// File: rtl/cache_mem_array.sv
// Single-port byte-enabled word RAM with a full-word backdoor write port.
// Contents have no reset so preloaded data survives a bus reset.
module cache_mem_array import cache_bus_pkg::*; #(
    parameter int unsigned Words = 4096,
    parameter int unsigned IdxW  = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [IdxW-1:0]   idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              bd_we_i,
    input  logic [IdxW-1:0]   bd_idx_i,
    input  logic [DATA_W-1:0] bd_wdata_i
);

    logic [DATA_W-1:0] mem_q [Words];

    // Bus byte writes first; the backdoor assignment comes later so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (bd_we_i) begin
            mem_q[bd_idx_i] <= bd_wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: one outstanding transaction, programmable grant
// and response latency, word SRAM behind it with a preload backdoor.
module cache_mem_responder import cache_bus_pkg::*; #(
    parameter int unsigned       MEM_WORDS      = 4096,
    parameter logic [ADDR_W-1:0] ADDR_BASE      = 32'h0000_0000,
    parameter int unsigned       GNT_LATENCY    = 1,
    parameter int unsigned       RVALID_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_mem_responder_if.slave bus,
    input  logic                 bd_we_i,
    input  logic [ADDR_W-1:0]    bd_addr_i,
    input  logic [DATA_W-1:0]    bd_wdata_i
);

    localparam int unsigned IdxW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CntMax = (GNT_LATENCY > RVALID_LATENCY) ? GNT_LATENCY
                                                                    : RVALID_LATENCY;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] GntCnt = CntW'(GNT_LATENCY);
    localparam logic [CntW-1:0] RvCnt  = CntW'(RVALID_LATENCY);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    resp_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              gnt;
    logic              rvalid;

    addr_dec_t         bus_dec;
    addr_dec_t         bd_dec;
    logic [DATA_W-1:0] arr_rdata;
    logic              unused_idx;

    assign bus_dec = addr_decode(bus.mem_addr_i, ADDR_BASE, ADDR_W'(MEM_WORDS));
    assign bd_dec  = addr_decode(bd_addr_i, ADDR_BASE, ADDR_W'(MEM_WORDS));
    assign unused_idx = ^{bus_dec.index[ADDR_W-1:IdxW], bd_dec.index[ADDR_W-1:IdxW]};

    cache_mem_array #(
        .Words (MEM_WORDS),
        .IdxW  (IdxW)
    ) u_array (
        .clk        (clk),
        .we_i       (accept && bus.mem_we_i && bus_dec.in_range),
        .be_i       (bus.mem_be_i),
        .idx_i      (bus_dec.index[IdxW-1:0]),
        .wdata_i    (bus.mem_wdata_i),
        .rdata_o    (arr_rdata),
        .bd_we_i    (bd_we_i && bd_dec.in_range),
        .bd_idx_i   (bd_dec.index[IdxW-1:0]),
        .bd_wdata_i (bd_wdata_i)
    );

    // Next-state, latency counting and the combinational gnt/rvalid strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // reset gating keeps a zero-latency gnt quiet while reset is held
                if (bus.mem_req_i && !reset) begin
                    cnt_d = CntOne;
                    if (GNT_LATENCY == 0) begin
                        accept  = 1'b1;
                        gnt     = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StGntWait;
                    end
                end
            end
            StGntWait: begin
                if (!bus.mem_req_i) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == GntCnt) begin
                    accept  = 1'b1;
                    gnt     = 1'b1;
                    cnt_d   = CntOne;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StResp: begin
                if (cnt_q == RvCnt) begin
                    rvalid  = 1'b1;
                    cnt_d   = '0;
                    state_d = StCooldown;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StCooldown: begin
                // absorbs the cache's lingering req after a write response
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and response registers; response is captured on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rdata_q <= (!bus.mem_we_i && bus_dec.in_range) ? arr_rdata : '0;
                err_q   <= !bus_dec.in_range;
            end
        end
    end

    assign bus.mem_gnt_o    = gnt;
    assign bus.mem_rvalid_o = rvalid;
    assign bus.mem_rdata_o  = rvalid ? rdata_q : '0;
    assign bus.mem_error_o  = rvalid && err_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: three instances with different latencies,
// bases and depths, driven by directed and random transactions against a word model.
module tb_cache_mem_responder;
    import cache_bus_pkg::*;

    localparam int NDut = 3;
    localparam int unsigned GntLat [NDut] = '{1, 3, 0};
    localparam int unsigned RvLat  [NDut] = '{1, 2, 1};
    localparam int unsigned Words  [NDut] = '{4096, 256, 64};
    localparam logic [31:0] Base   [NDut] = '{32'h0000_0000, 32'h0000_1000, 32'h8000_0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s      [NDut];
    logic        req_s      [NDut];
    logic        we_s       [NDut];
    logic [31:0] addr_s     [NDut];
    logic [31:0] wdata_s    [NDut];
    logic [3:0]  be_s       [NDut];
    logic        bd_we_s    [NDut];
    logic [31:0] bd_addr_s  [NDut];
    logic [31:0] bd_wdata_s [NDut];
    logic        gnt_s      [NDut];
    logic        rvalid_s   [NDut];
    logic        err_s      [NDut];
    logic [31:0] rdata_s    [NDut];

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        cache_mem_responder_if bus ();
        assign bus.mem_addr_i  = addr_s[g];
        assign bus.mem_wdata_i = wdata_s[g];
        assign bus.mem_we_i    = we_s[g];
        assign bus.mem_req_i   = req_s[g];
        assign bus.mem_be_i    = be_s[g];
        assign gnt_s[g]        = bus.mem_gnt_o;
        assign rvalid_s[g]     = bus.mem_rvalid_o;
        assign err_s[g]        = bus.mem_error_o;
        assign rdata_s[g]      = bus.mem_rdata_o;

        cache_mem_responder #(
            .MEM_WORDS      (Words[g]),
            .ADDR_BASE      (Base[g]),
            .GNT_LATENCY    (GntLat[g]),
            .RVALID_LATENCY (RvLat[g])
        ) u_dut (
            .clk        (clk),
            .reset      (rst_s[g]),
            .bus        (bus),
            .bd_we_i    (bd_we_s[g]),
            .bd_addr_i  (bd_addr_s[g]),
            .bd_wdata_i (bd_wdata_s[g])
        );
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mdl [NDut][4096];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_in_range(input int d, input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, Base[d]});
        return (off >= 0) && (off < 4 * longint'(Words[d]));
    endfunction

    function automatic int unsigned ref_index(input int d, input logic [31:0] a);
        return int'((a - Base[d]) / 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int d, input logic [31:0] a, input logic [31:0] data);
        bd_we_s[d]    = 1'b1;
        bd_addr_s[d]  = a;
        bd_wdata_s[d] = data;
        tick();
        bd_we_s[d] = 1'b0;
        if (ref_in_range(d, a)) mdl[d][ref_index(d, a)] = data;
    endtask

    // One bus transaction; hold keeps req high through the cycle after rvalid,
    // coll fires a backdoor write to the same address on the accept edge.
    task automatic bus_txn(input int d, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input bit hold,
                           input bit coll, input logic [31:0] coll_data, input string tag,
                           output logic [31:0] got_rd);
        bit          inr;
        int unsigned idx;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          gnt_cnt, rv_cnt, gnt_cyc, rv_cyc, stray;
        logic [31:0] rd;
        logic        er;
        gnt_cnt = 0; rv_cnt = 0; gnt_cyc = -1; rv_cyc = -1; stray = 0;
        rd = 32'h0; er = 1'b0;
        inr     = ref_in_range(d, a);
        idx     = inr ? ref_index(d, a) : 0;
        exp_rd  = (inr && !we) ? mdl[d][idx] : 32'h0;
        exp_err = !inr;
        req_s[d] = 1'b1; we_s[d] = we; addr_s[d] = a; wdata_s[d] = wd; be_s[d] = be;
        bd_addr_s[d] = a; bd_wdata_s[d] = coll_data;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bd_we_s[d] = coll && (cyc == int'(GntLat[d]));
            @(negedge clk);
            if (gnt_s[d]) begin
                gnt_cnt++;
                if (gnt_cnt == 1) gnt_cyc = cyc;
            end
            if (rvalid_s[d]) begin
                rv_cnt++;
                if (rv_cnt == 1) begin
                    rv_cyc = cyc; rd = rdata_s[d]; er = err_s[d];
                end
            end else if (rdata_s[d] !== 32'h0 || err_s[d] !== 1'b0) begin
                stray++;
            end
            tick();
            if (!hold && gnt_cnt > 0) req_s[d] = 1'b0;
            if (hold && rv_cnt > 0 && cyc >= rv_cyc + 1) req_s[d] = 1'b0;
            if (rv_cnt > 0 && cyc >= rv_cyc + 3) break;
        end
        req_s[d] = 1'b0; we_s[d] = 1'b0; bd_we_s[d] = 1'b0;
        check_eq({tag, " gnt_count"}, 32'(gnt_cnt), 32'd1);
        check_eq({tag, " rvalid_count"}, 32'(rv_cnt), 32'd1);
        check_eq({tag, " gnt_cycle"}, 32'(gnt_cyc), GntLat[d]);
        check_eq({tag, " rvalid_cycle"}, 32'(rv_cyc), GntLat[d] + RvLat[d]);
        check_eq({tag, " rdata"}, rd, exp_rd);
        check_eq({tag, " error"}, {31'h0, er}, {31'h0, exp_err});
        check_eq({tag, " idle_outputs"}, 32'(stray), 32'd0);
        if (inr && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (coll && inr) mdl[d][idx] = coll_data;
        got_rd = rd;
    endtask

    // Read with req held for nreq cycles; records which cycles carried gnt/rvalid.
    task automatic cont_req(input int d, input logic [31:0] a, input int nreq, input int ntot,
                            input logic [15:0] exp_gnt, input logic [15:0] exp_rv,
                            input string tag);
        logic [15:0] gv, rv;
        int          bad;
        gv = 16'h0; rv = 16'h0; bad = 0;
        req_s[d] = 1'b1; we_s[d] = 1'b0; addr_s[d] = a;
        for (int cyc = 0; cyc < ntot; cyc++) begin
            @(negedge clk);
            gv[cyc] = gnt_s[d];
            rv[cyc] = rvalid_s[d];
            if (rvalid_s[d] && rdata_s[d] !== mdl[d][ref_index(d, a)]) bad++;
            tick();
            if (cyc + 1 >= nreq) req_s[d] = 1'b0;
        end
        check_eq({tag, " gnt_cycles"}, {16'h0, gv}, {16'h0, exp_gnt});
        check_eq({tag, " rvalid_cycles"}, {16'h0, rv}, {16'h0, exp_rv});
        check_eq({tag, " rdata_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          kind, gap, seen;
        for (int d = 0; d < NDut; d++) begin
            rst_s[d] = 1'b1; req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = 32'h0;
            wdata_s[d] = 32'h0; be_s[d] = 4'h0; bd_we_s[d] = 1'b0;
            bd_addr_s[d] = 32'h0; bd_wdata_s[d] = 32'h0;
        end
        // zero-latency instance sees req during reset: gnt must stay low
        req_s[2] = 1'b1; addr_s[2] = Base[2];
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDut; d++) begin
            check_eq($sformatf("reset gnt[%0d]", d), {31'h0, gnt_s[d]}, 32'h0);
            check_eq($sformatf("reset rvalid[%0d]", d), {31'h0, rvalid_s[d]}, 32'h0);
            check_eq($sformatf("reset rdata[%0d]", d), rdata_s[d], 32'h0);
            check_eq($sformatf("reset error[%0d]", d), {31'h0, err_s[d]}, 32'h0);
        end
        req_s[2] = 1'b0;
        for (int d = 0; d < NDut; d++) rst_s[d] = 1'b0;
        tick();

        // Preload every word of every instance through the backdoor.
        for (int i = 0; i < 4096; i++) begin
            for (int d = 0; d < NDut; d++) begin
                bd_we_s[d] = (i < int'(Words[d]));
                bd_addr_s[d] = Base[d] + 32'(4 * i);
                bd_wdata_s[d] = $urandom;
                if (i < int'(Words[d])) mdl[d][i] = bd_wdata_s[d];
            end
            tick();
        end
        for (int d = 0; d < NDut; d++) bd_we_s[d] = 1'b0;

        // Basic read and byte-enabled write on the default instance.
        bd_write(0, 32'h14, 32'hDEAD_BEEF);
        bus_txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "rd14", rd);
        check_eq("rd14 const", rd, 32'hDEAD_BEEF);
        bd_write(0, 32'h20, 32'hFFFF_FFFF);
        bus_txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 32'h0, "wr20", rd);
        bus_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "rb20", rd);
        check_eq("rb20 const", rd, 32'hFF22_FF44);

        // Cache-style write holding req past rvalid, then back-to-back reads.
        bus_txn(0, 1'b1, 32'h40, 32'hA5A5_5A5A, 4'hF, 1'b1, 1'b0, 32'h0, "hold_wr", rd);
        cont_req(0, 32'h40, 8, 11, 16'h0022, 16'h0044, "b2b_a");
        cont_req(2, Base[2] + 32'h4, 6, 9, 16'h0009, 16'h0012, "b2b_c");

        // Abandoned request on the long-latency instance.
        req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = Base[1] + 32'd40;
        wdata_s[1] = 32'h0BAD_0BAD; be_s[1] = 4'hF;
        seen = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (gnt_s[1] || rvalid_s[1]) seen++;
            tick();
            if (cyc == 1) req_s[1] = 1'b0;
        end
        we_s[1] = 1'b0;
        check_eq("drop no_gnt", 32'(seen), 32'd0);
        bus_txn(1, 1'b0, Base[1] + 32'd40, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "drop_rb", rd);

        // Out-of-range accesses.
        bus_txn(0, 1'b0, Base[0] + 32'(4 * Words[0]), 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "oor_rd", rd);
        bus_txn(2, 1'b1, Base[2] + 32'(4 * Words[2]), 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0,
                32'h0, "oor_wr", rd);
        bd_write(2, Base[2] + 32'(4 * Words[2]) + 32'h4, 32'h1357_9BDF);
        bus_txn(1, 1'b0, Base[1] - 32'h4, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "below_base", rd);

        // Backdoor vs bus write on the same edge.
        bus_txn(2, 1'b1, Base[2] + 32'd28, 32'h1111_1111, 4'hF, 1'b0, 1'b1, 32'hC0FF_EE00,
                "coll_wr", rd);
        bus_txn(2, 1'b0, Base[2] + 32'd28, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "coll_rb", rd);
        check_eq("coll const", rd, 32'hC0FF_EE00);

        // Reset during the response cycle.
        bus_txn(1, 1'b1, Base[1] + 32'd80, 32'h7E57_0001, 4'hF, 1'b0, 1'b0, 32'h0, "pre_rst", rd);
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = Base[1] + 32'd80;
        repeat (4) tick();
        req_s[1] = 1'b0;
        tick();
        check_eq("rst pre rvalid", {31'h0, rvalid_s[1]}, 32'h1);
        rst_s[1] = 1'b1;
        #1;
        check_eq("rst rvalid", {31'h0, rvalid_s[1]}, 32'h0);
        check_eq("rst rdata", rdata_s[1], 32'h0);
        check_eq("rst error", {31'h0, err_s[1]}, 32'h0);
        tick();
        rst_s[1] = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (rvalid_s[1] || gnt_s[1]) seen++;
            tick();
        end
        check_eq("rst no_rvalid", 32'(seen), 32'd0);
        bus_txn(1, 1'b0, Base[1] + 32'd80, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "post_rst", rd);
        check_eq("post_rst const", rd, 32'h7E57_0001);

        // Random traffic on every instance.
        for (int d = 0; d < NDut; d++) begin
            for (int n = 0; n < 40; n++) begin
                kind = int'($urandom_range(0, 9));
                if (kind == 0) begin
                    a = Base[d] + 32'(4 * Words[d]) + 32'(4 * $urandom_range(0, 15));
                end else if (kind == 1) begin
                    a = (Base[d] == 32'h0) ? 32'hFFFF_FFF0 : Base[d] - 32'(4 * $urandom_range(1, 8));
                end else begin
                    a = Base[d] + 32'(4 * $urandom_range(0, Words[d] - 1)) + 32'($urandom_range(0, 3));
                end
                bus_txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom,
                        $sformatf("rnd%0d_%0d", d, n), rd);
                gap = int'($urandom_range(0, 2));
                for (int k = 0; k < gap; k++) tick();
            end
        end

        // Full sweep of the small instance catches aliasing or lost writes.
        for (int i = 0; i < int'(Words[2]); i++) begin
            bus_txn(2, 1'b0, Base[2] + 32'(4 * i), 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                    $sformatf("sweep%0d", i), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
